// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the CPU MEM
// stage and the debug/loader port. CPU has fixed priority, a starvation
// counter guarantees DBG progress, and a lock mode hands DBG exclusive
// ownership. Read data is steered back to the port that issued the read.
module dmem_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [XLEN-1:0]   cpu_addr_i,
  input  logic [XLEN-1:0]   cpu_wdata_i,
  input  logic [3:0]        cpu_be_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [XLEN-1:0]   cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [XLEN-1:0]   dbg_addr_i,
  input  logic [XLEN-1:0]   dbg_wdata_i,
  input  logic [3:0]        dbg_be_i,
  input  logic              dbg_lock_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [XLEN-1:0]   dbg_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] starve_q;
  logic       rd_pend_q;
  logic       rd_owner_q;  // 0 = CPU, 1 = DBG

  // Byte address bits outside the word index are not used by the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr_i[XLEN-1:ADDR_W+2], cpu_addr_i[1:0],
                              dbg_addr_i[XLEN-1:ADDR_W+2], dbg_addr_i[1:0]};

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= ST_ARB;
    else         state_q <= state_d;
  end

  // Next state: enter lock only on a cycle DBG actually owns the memory;
  // leave once lock drops (DBG still owns that final cycle).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:  if (dbg_gnt_o && dbg_lock_i) state_d = ST_LOCK;
      ST_LOCK: if (!dbg_lock_i)             state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Grant decode; grants are held off while reset is asserted so the
  // memory sees no strobe during the reset cycle.
  always_comb begin
    cpu_gnt_o = 1'b0;
    dbg_gnt_o = 1'b0;
    if (rstn_i) begin
      case (state_q)
        ST_ARB: begin
          if (dbg_req_i && (starve_q == LIMIT)) dbg_gnt_o = 1'b1;
          else if (cpu_req_i)                   cpu_gnt_o = 1'b1;
          else if (dbg_req_i)                   dbg_gnt_o = 1'b1;
        end
        ST_LOCK: dbg_gnt_o = dbg_req_i;
        default: ;
      endcase
    end
  end

  // Memory port mux: winner's fields, all zero when idle.
  always_comb begin
    mem_en_o    = cpu_gnt_o | dbg_gnt_o;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (cpu_gnt_o) begin
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i[ADDR_W+1:2];
      mem_wdata_o = cpu_wdata_i;
      mem_be_o    = cpu_be_i;
    end else if (dbg_gnt_o) begin
      mem_we_o    = dbg_we_i;
      mem_addr_o  = dbg_addr_i[ADDR_W+1:2];
      mem_wdata_o = dbg_wdata_i;
      mem_be_o    = dbg_be_i;
    end
  end

  // Starvation counter: counts DBG cycles lost, saturates at the limit.
  always_ff @(posedge clk_i) begin
    if (!rstn_i)                       starve_q <= '0;
    else if (dbg_req_i && !dbg_gnt_o)  starve_q <= (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
    else                               starve_q <= '0;
  end

  // Remember who issued the read so the return can be steered next cycle.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= (cpu_gnt_o && !cpu_we_i) || (dbg_gnt_o && !dbg_we_i);
      rd_owner_q <= dbg_gnt_o;
    end
  end

  // Read return steering; a return in flight across reset is dropped.
  always_comb begin
    cpu_rvalid_o = rstn_i && rd_pend_q && !rd_owner_q;
    dbg_rvalid_o = rstn_i && rd_pend_q &&  rd_owner_q;
    cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
    dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : '0;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port). CPU has fixed priority; a starvation counter guarantees DBG progress, and a lock mode gives DBG exclusive ownership for program/data loading. Memory read latency is one cycle; read data is steered back to the port that issued the read.

## Interface
Parameters:
- ADDR_W, 7, word-index width of the memory (128 words)
- STARVE_LIMIT, 4, DBG waiting cycles before it wins one grant over CPU; legal 1..15

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; one clock, reset is synchronous and active-low
- cpu_req_i / dbg_req_i  in  1  access request
- cpu_we_i / dbg_we_i  in  1  1 = write, 0 = read
- cpu_addr_i / dbg_addr_i  in  XLEN  byte address; word index = addr[ADDR_W+1:2]
- cpu_wdata_i / dbg_wdata_i  in  XLEN  write data
- cpu_be_i / dbg_be_i  in  4  byte enables
- dbg_lock_i  in  1  request exclusive ownership
- cpu_gnt_o / dbg_gnt_o  out  1  request accepted this cycle (CPU stalls while cpu_req_i & !cpu_gnt_o)
- cpu_rvalid_o / dbg_rvalid_o  out  1  read data valid
- cpu_rdata_o / dbg_rdata_o  out  XLEN  read data; 0 when matching rvalid is low
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  write strobe
- mem_addr_o  out  ADDR_W  word index
- mem_wdata_o  out  XLEN  write data
- mem_be_o  out  4  byte enables
- mem_rdata_i  in  XLEN  read data, valid one cycle after a read strobe

## Operation
- FSM states: ARB, DBG_LOCK. Reset state ARB.
- ARB winner (combinational, same cycle): DBG if dbg_req_i & (starve_cnt == STARVE_LIMIT); else CPU if cpu_req_i; else DBG if dbg_req_i; else none. At most one gnt high.
- DBG_LOCK: cpu_gnt_o = 0; dbg_gnt_o = dbg_req_i.
- ARB -> DBG_LOCK: at edge where dbg_gnt_o & dbg_lock_i. DBG_LOCK -> ARB: at edge where dbg_lock_i = 0 (DBG still owns that cycle).
- starve_cnt (4 bit): +1 each cycle dbg_req_i & !dbg_gnt_o, saturating at STARVE_LIMIT; cleared when dbg_gnt_o or !dbg_req_i.
- Memory drive: mem_en_o = any gnt; mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o = winner's fields; all 0 when no grant.
- Read return: register rd_pend (1 bit) and rd_owner (0 = CPU, 1 = DBG) captured on granted reads. Cycle after: owner's rvalid_o = 1, rdata_o = mem_rdata_i; other port rvalid 0, rdata 0.
- Writes produce no rvalid. Back-to-back reads, any owner mix, sustain one per cycle.

## Timing
- Grant to memory strobe: 0 cycles. Read grant at cycle N -> rvalid at N+1.
- Reset values: all gnt 0, all rvalid 0, all rdata 0, mem_en_o/mem_we_o 0, mem_addr_o/mem_wdata_o/mem_be_o 0, starve_cnt 0, state ARB, rd_pend 0.
- Reset during outstanding read: return is discarded; rvalid stays 0 in the following cycle.
- Simultaneous requests, starve_cnt < STARVE_LIMIT: CPU wins, DBG counter increments.
- Lock requested while DBG loses arbitration: no state change.
- dbg_lock_i with dbg_req_i = 0 in DBG_LOCK: memory idle, CPU still blocked.
- Requester must hold req and fields stable until gnt; arbiter does not buffer requests.

## Test plan
- CPU read addr 0x10 (mem word 4 = 0xDEADBEEF), DBG idle -> cpu_gnt_o same cycle, mem_addr_o = 4, cpu_rvalid_o next cycle with 0xDEADBEEF, dbg_rvalid_o = 0.
- CPU and DBG request continuously, STARVE_LIMIT = 4 -> grant pattern CPU×4, DBG×1, repeating; starve_cnt returns to 0 after each DBG grant.
- Alternating reads CPU@0x0, DBG@0x4, CPU@0x8 (one per cycle, DBG forced by starvation) -> rvalids return to correct port in order, no cross-port data leakage.
- DBG write with dbg_lock_i = 1, 8 consecutive writes while cpu_req_i held -> cpu_gnt_o = 0 throughout; after lock drops, CPU granted the cycle after the last locked cycle.
- Byte write be = 4'b0010, wdata 0x0000AB00 -> mem_be_o = 2, mem_we_o = 1, no rvalid.
- Assert rstn_i = 0 the cycle after a granted CPU read -> cpu_rvalid_o = 0, all outputs at reset values, state ARB after release.
